// File: rtl/life_pkg.sv
// Shared definitions for the cell block preset loader: load sequencer states,
// preset indices, pattern words and the random-pattern LFSR feedback taps.
package life_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_SYNC = 2'd1,
    S_WRITE     = 2'd2,
    S_DONE      = 2'd3
  } load_state_t;

  localparam logic [3:0] PRESET_CLEAR     = 4'd0;
  localparam logic [3:0] PRESET_BLINKER   = 4'd1;
  localparam logic [3:0] PRESET_BLOCK     = 4'd2;
  localparam logic [3:0] PRESET_GLIDER    = 4'd3;
  localparam logic [3:0] PRESET_ALL_ALIVE = 4'd4;
  localparam logic [3:0] PRESET_RANDOM    = 4'd15;

  localparam logic [15:0] WORD_BLINKER   = 16'h0070;
  localparam logic [15:0] WORD_BLOCK     = 16'h0660;
  localparam logic [15:0] WORD_GLIDER    = 16'h0742;
  localparam logic [15:0] WORD_ALL_ALIVE = 16'hFFFF;

  // Right-shifting form of taps 16,14,13,11: feedback is the XOR of bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Small patterns live entirely in tile 0; reserved selects load a clear board.
  function automatic logic [15:0] pattern_word(input logic [3:0] sel,
                                               input logic first_tile,
                                               input logic [15:0] rnd);
    logic [15:0] word;
    word = '0;
    case (sel)
      PRESET_BLINKER:   word = first_tile ? WORD_BLINKER : '0;
      PRESET_BLOCK:     word = first_tile ? WORD_BLOCK : '0;
      PRESET_GLIDER:    word = first_tile ? WORD_GLIDER : '0;
      PRESET_ALL_ALIVE: word = WORD_ALL_ALIVE;
      PRESET_RANDOM:    word = rnd;
      default:          word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it off the all-zero state.
module lfsr16
  import life_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {^(value & LFSR_TAPS), value[15:1]};
    end
  end

endmodule

// File: rtl/preset_loader.sv
// Loads a selected starting pattern into the cell block memory as a burst of
// tile writes, synchronised to the frame boundary and an idle generation controller.
module preset_loader
  import life_pkg::*;
#(
  parameter int          NUM_TILES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_req,
  input  logic [3:0]                   preset_sel,
  input  logic                         frame,
  input  logic                         ctrl_idle,
  output logic                         hold,
  output logic                         mem_write_enb,
  output logic [$clog2(NUM_TILES)-1:0] mem_array_sel,
  output logic [15:0]                  mem_alive_in,
  output logic                         busy,
  output logic                         done,
  output logic [7:0]                   load_count
);

  localparam int TW = $clog2(NUM_TILES);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  load_state_t   state_q, state_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    count_q, count_d;
  logic [15:0]   rnd;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (rnd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      sel_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      sel_q   <= sel_d;
      count_q <= count_d;
    end
  end

  // Requests are only looked at in IDLE, so anything arriving mid-load is dropped.
  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    sel_d   = sel_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          sel_d   = preset_sel;
          state_d = S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (frame && ctrl_idle) begin
          tile_d  = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (tile_q == LAST_TILE) begin
          count_d = count_q + 8'd1;
          state_d = S_DONE;
        end else begin
          tile_d = tile_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from flops only; no input reaches an output combinationally.
  always_comb begin
    busy          = (state_q != S_IDLE);
    hold          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    mem_write_enb = (state_q == S_WRITE);
    mem_array_sel = (state_q == S_WRITE) ? tile_q : '0;
    mem_alive_in  = (state_q == S_WRITE) ? pattern_word(sel_q, (tile_q == '0), rnd) : '0;
    load_count    = count_q;
  end

endmodule

// File: tb/tb_preset_loader.sv
// Directed-plus-random bench for preset_loader with a reference pattern table and
// an independent arithmetic LFSR model.
module tb_preset_loader;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [3:0]  preset_sel;
  logic        frame;
  logic        ctrl_idle;
  logic        hold;
  logic        mem_write_enb;
  logic [1:0]  mem_array_sel;
  logic [15:0] mem_alive_in;
  logic        busy;
  logic        done;
  logic [7:0]  load_count;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_count = 8'd0;
  logic [63:0] words;
  logic [63:0] prev_words;
  int          m_lfsr;

  preset_loader dut (
    .clk           (clk),
    .reset         (reset),
    .load_req      (load_req),
    .preset_sel    (preset_sel),
    .frame         (frame),
    .ctrl_idle     (ctrl_idle),
    .hold          (hold),
    .mem_write_enb (mem_write_enb),
    .mem_array_sel (mem_array_sel),
    .mem_alive_in  (mem_alive_in),
    .busy          (busy),
    .done          (done),
    .load_count    (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: shift right, new MSB = XOR of bits 0,2,3,5.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 32'hACE1;
    else m_lfsr <= (m_lfsr >> 1) | ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_word(input int sel, input int tile, input int rnd);
    logic [15:0] tile0_table [16];
    for (int i = 0; i < 16; i++) tile0_table[i] = 16'h0000;
    tile0_table[1] = 16'h0070;
    tile0_table[2] = 16'h0660;
    tile0_table[3] = 16'h0742;
    if (sel == 15) return rnd[15:0];
    if (sel == 4) return 16'hFFFF;
    if (tile != 0) return 16'h0000;
    return tile0_table[sel];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] sel);
    preset_sel = sel;
    load_req   = 1'b1;
    step();
    load_req   = 1'b0;
    check("req_busy", busy, 1);
    check("req_hold", hold, 1);
    check("req_wr_idle", mem_write_enb, 0);
  endtask

  task automatic pulse_frame(input logic idle);
    frame     = 1'b1;
    ctrl_idle = idle;
    step();
    frame     = 1'b0;
  endtask

  // Entered on the cycle after the qualifying frame; leaves one cycle after done.
  task automatic check_load(input int sel, input bit noise);
    for (int t = 0; t < 4; t++) begin
      check("wr_en", mem_write_enb, 1);
      check("wr_addr", mem_array_sel, t);
      check("wr_data", mem_alive_in, model_word(sel, t, m_lfsr));
      check("wr_hold", hold, 1);
      check("wr_done", done, 0);
      if (sel == 15) check("rnd_nonzero", (mem_alive_in != 16'h0), 1);
      words[16*t +: 16] = mem_alive_in;
      if (noise) begin
        load_req   = 1'($urandom_range(0, 1));
        preset_sel = 4'($urandom);
        ctrl_idle  = 1'($urandom_range(0, 1));
        frame      = 1'($urandom_range(0, 1));
      end
      step();
    end
    exp_count = exp_count + 8'd1;
    check("done_pulse", done, 1);
    check("done_wr", mem_write_enb, 0);
    check("done_busy", busy, 1);
    check("done_hold", hold, 1);
    check("done_count", load_count, exp_count);
    load_req = 1'b0;
    frame    = 1'b0;
    step();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_hold", hold, 0);
    check("post_wr", mem_write_enb, 0);
  endtask

  initial begin
    reset = 1'b1; load_req = 1'b0; preset_sel = 4'd0; frame = 1'b0; ctrl_idle = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_count", load_count, 0);
    check("rst_outs", {hold, busy, done, mem_write_enb, mem_array_sel, mem_alive_in}, 0);

    // Idle soak with random frame/ctrl_idle traffic and no requests.
    for (int i = 0; i < 1000; i++) begin
      frame     = 1'($urandom_range(0, 1));
      ctrl_idle = 1'($urandom_range(0, 1));
      step();
      check("idle_quiet", {hold, busy, mem_write_enb}, 0);
    end
    frame = 1'b0;
    check("idle_count", load_count, 0);

    // Reset on the second write cycle abandons the load.
    ctrl_idle = 1'b1;
    request(4'd3);
    repeat (4) step();
    pulse_frame(1'b1);
    check("rw_en0", mem_write_enb, 1);
    check("rw_data0", mem_alive_in, 16'h0742);
    step();
    check("rw_en1", mem_write_enb, 1);
    check("rw_addr1", mem_array_sel, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_outs", {hold, busy, done, mem_write_enb, mem_array_sel, mem_alive_in}, 0);
    check("rw_count", load_count, exp_count);
    request(4'd1);
    repeat (2) step();
    pulse_frame(1'b1);
    check_load(1, 0);

    // Glider, frame 50 cycles after the request.
    request(4'd3);
    ctrl_idle = 1'b1;
    repeat (49) step();
    check("g_wait_wr", mem_write_enb, 0);
    check("g_wait_busy", busy, 1);
    pulse_frame(1'b1);
    check_load(3, 0);

    // All-alive: first frame arrives while the controller is busy.
    request(4'd4);
    repeat ($urandom_range(5, 40)) step();
    pulse_frame(1'b0);
    for (int i = 0; i < 5; i++) begin
      check("aa_skip_wr", mem_write_enb, 0);
      check("aa_skip_busy", busy, 1);
      step();
    end
    pulse_frame(1'b1);
    check_load(4, 0);

    // Repeated requests and a select change mid-load are ignored.
    ctrl_idle = 1'b1;
    request(4'd2);
    for (int i = 0; i < 10; i++) begin
      load_req   = 1'($urandom_range(0, 1));
      preset_sel = 4'd0;
      step();
      check("nz_wait_wr", mem_write_enb, 0);
    end
    load_req = 1'b1;
    pulse_frame(1'b1);
    check_load(2, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("nz_single", busy, 0);
    end

    // Random preset, two back-to-back loads.
    ctrl_idle = 1'b1;
    request(4'd15);
    repeat (3) step();
    pulse_frame(1'b1);
    check_load(15, 0);
    prev_words = words;
    request(4'd15);
    repeat (2) step();
    pulse_frame(1'b1);
    check_load(15, 0);
    check("rnd_differ", (prev_words != words), 1);

    // Random selects and waits, including reserved indices.
    for (int n = 0; n < 8; n++) begin
      request(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 20)) step();
      pulse_frame(1'b1);
      check_load(preset_sel, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
